// File: rtl/fec_chain_sequencer.sv
// Frame sequencer for an encoder/modulator/demodulator/decoder chain.
// Fills a frame buffer, drains it through a 4-stage valid pipe, flushes, then reports completion.
module fec_chain_sequencer #(
  parameter int FRAME_LEN  = 16,
  parameter int PIPE_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req,
  input  logic       in_valid,
  input  logic       buff_empty,
  input  logic       buff_full,
  output logic       ack,
  output logic       wr_en_buff,
  output logic       rd_en_buff,
  output logic       en_encoder,
  output logic       en_modulator,
  output logic       en_demodulator,
  output logic       en_decoder,
  output logic       busy,
  output logic       frame_done,
  output logic       err_overflow,
  output logic [7:0] frame_cnt
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DRAIN,
    FLUSH,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic [PIPE_DEPTH-1:0] v_q, v_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  err_q, err_d;
  logic                  ack_q, ack_d;
  logic                  wr_en, rd_en, done;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
      ack_q       <= ack_d;
    end
  end

  // Every state advance is qualified by en, so en=0 freezes the whole block.
  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_q;
    ack_d       = 1'b0;
    wr_en       = 1'b0;
    rd_en       = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (en && req) begin
          state_d  = FILL;
          ack_d    = 1'b1;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
        end
      end
      FILL: begin
        wr_en = en & in_valid & ~buff_full;
        if (en && in_valid && buff_full) begin
          err_d = 1'b1;
        end
        if (wr_en) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q == LAST) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        rd_en = en & ~buff_empty;
        if (rd_en) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == LAST) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (en && (v_q == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (en) begin
          done        = 1'b1;
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    v_d = en ? {v_q[PIPE_DEPTH-2:0], rd_en} : v_q;
  end

  assign ack            = ack_q;
  assign wr_en_buff     = wr_en;
  assign rd_en_buff     = rd_en;
  assign en_encoder     = v_q[0] & en;
  assign en_modulator   = v_q[1] & en;
  assign en_demodulator = v_q[2] & en;
  assign en_decoder     = v_q[3] & en;
  assign busy           = (state_q != IDLE);
  assign frame_done     = done;
  assign err_overflow   = err_q;
  assign frame_cnt      = frame_cnt_q;

endmodule
